// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg -- shared constants, state type and helpers for the iterative
// 32x32 -> 64 multiplier (mul_iter).
//   OP_W      operand width
//   STEPS_R2  iterations for the radix-2 datapath
//   STEPS_R4  iterations for the radix-4 (modified Booth) datapath
//   ACC_W     width of the running upper partial product (two guard bits)
//   CNT_W     step counter width
// Build option: MUL_ITER_RADIX4_EN selects the radix-4 datapath in the
// files that import this package.
package mul_iter_pkg;

    localparam int unsigned OP_W     = 32;
    localparam int unsigned STEPS_R2 = 32;
    localparam int unsigned STEPS_R4 = 16;
    localparam int unsigned ACC_W    = OP_W + 2;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widen an operand by one bit: sign bit for signed mode, zero for unsigned.
    function automatic logic [OP_W:0] ext_operand(input logic [OP_W-1:0] v,
                                                  input logic is_unsigned);
        ext_operand = {(~is_unsigned & v[OP_W-1]), v};
    endfunction

endpackage

// File: rtl/mul_iter_step.sv
// mul_iter_step -- one combinational iteration of the shift-add multiplier.
// The product is held as {acc, q}: acc is the signed upper partial product,
// q holds the not-yet-consumed multiplier bits, and the low product bits
// shift into q from the top.
// Build option MUL_ITER_RADIX4_EN: radix-4 modified Booth (2 bits per step,
// carries a previous-bit input), otherwise radix-2 (1 bit per step).
// Ports:
//   i_acc/o_acc  upper partial product (ACC_W bits, two's complement)
//   i_q/o_q      multiplier / low product shift register
//   i_prev/o_prev  Booth overlap bit (radix-4 build only)
//   i_xe         multiplicand widened by one bit (sign or zero)
//   i_last       this is the final iteration
//   i_unsigned   unsigned product mode
module mul_iter_step
    import mul_iter_pkg::*;
(
    input  logic [ACC_W-1:0] i_acc,
    input  logic [OP_W-1:0]  i_q,
`ifdef MUL_ITER_RADIX4_EN
    input  logic             i_prev,
    output logic             o_prev,
`endif
    input  logic [OP_W:0]    i_xe,
    input  logic             i_last,
    input  logic             i_unsigned,
    output logic [ACC_W-1:0] o_acc,
    output logic [OP_W-1:0]  o_q
);

`ifdef MUL_ITER_RADIX4_EN
    localparam int unsigned SUM_W = ACC_W + 2;

    logic [SUM_W-1:0] w_acc_ext;
    logic [SUM_W-1:0] w_x1;
    logic [SUM_W-1:0] w_x2;
    logic [SUM_W-1:0] w_x3;
    logic [SUM_W-1:0] w_x4;
    logic [SUM_W-1:0] w_mult;
    logic [SUM_W-1:0] w_sum;
    logic [2:0]       w_grp;

    // Booth digit selection, add and 2-bit arithmetic shift.
    // Unsigned mode folds the implicit +2^32*x*y[31] correction into the last
    // digit, which then ranges 0..+4 instead of -2..+2.
    always_comb begin
        w_acc_ext = {{(SUM_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
        w_x1      = {{(SUM_W-OP_W-1){i_xe[OP_W]}}, i_xe};
        w_x2      = w_x1 << 1;
        w_x4      = w_x1 << 2;
        w_x3      = w_x1 + w_x2;
        w_grp     = {i_q[1], i_q[0], i_prev};
        w_mult    = '0;
        if (i_last && i_unsigned) begin
            case (w_grp)
                3'b000:  w_mult = '0;
                3'b001:  w_mult = w_x1;
                3'b010:  w_mult = w_x1;
                3'b011:  w_mult = w_x2;
                3'b100:  w_mult = w_x2;
                3'b101:  w_mult = w_x3;
                3'b110:  w_mult = w_x3;
                3'b111:  w_mult = w_x4;
                default: w_mult = '0;
            endcase
        end else begin
            case (w_grp)
                3'b000:  w_mult = '0;
                3'b001:  w_mult = w_x1;
                3'b010:  w_mult = w_x1;
                3'b011:  w_mult = w_x2;
                3'b100:  w_mult = -w_x2;
                3'b101:  w_mult = -w_x1;
                3'b110:  w_mult = -w_x1;
                3'b111:  w_mult = '0;
                default: w_mult = '0;
            endcase
        end
        w_sum  = w_acc_ext + w_mult;
        o_acc  = w_sum[SUM_W-1:2];
        o_q    = {w_sum[1:0], i_q[OP_W-1:2]};
        o_prev = i_q[1];
    end
`else
    localparam int unsigned SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] w_acc_ext;
    logic [SUM_W-1:0] w_x_ext;
    logic [SUM_W-1:0] w_sum;

    // Conditional add and 1-bit arithmetic shift. In signed mode bit 31 of
    // the multiplier has weight -2^31, so the last step subtracts.
    always_comb begin
        w_acc_ext = {{(SUM_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
        w_x_ext   = {{(SUM_W-OP_W-1){i_xe[OP_W]}}, i_xe};
        if (i_q[0]) begin
            if (i_last && !i_unsigned) begin
                w_sum = w_acc_ext - w_x_ext;
            end else begin
                w_sum = w_acc_ext + w_x_ext;
            end
        end else begin
            w_sum = w_acc_ext;
        end
        o_acc = w_sum[SUM_W-1:1];
        o_q   = {w_sum[0], i_q[OP_W-1:1]};
    end
`endif

endmodule

// File: rtl/mul_iter.sv
// mul_iter -- iterative 32x32 -> 64 multiplier, signed or unsigned.
// Handshake: initiator holds run high; stall stays high until z is valid.
// Build option MUL_ITER_RADIX4_EN: radix-4 Booth, 16 steps (stall 17 cycles);
// default radix-2, 32 steps (stall 33 cycles).
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   run          operation request, held for the whole operation
//   op_unsigned  1 = unsigned, 0 = two's-complement product
//   x, y         operands, captured on the accept cycle only
//   stall        high while the result is not yet valid (combinational)
//   z            64-bit product, straight from the working registers
module mul_iter
    import mul_iter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              op_unsigned,
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    output logic              stall,
    output logic [2*OP_W-1:0] z
);

`ifdef MUL_ITER_RADIX4_EN
    localparam int unsigned STEPS = STEPS_R4;
`else
    localparam int unsigned STEPS = STEPS_R2;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [OP_W-1:0]  r_q;
    logic [OP_W:0]    r_xe;
    logic             r_uns;
    logic [ACC_W-1:0] w_acc_n;
    logic [OP_W-1:0]  w_q_n;
    logic             w_last;
    logic             w_accept;
    logic             w_step;
`ifdef MUL_ITER_RADIX4_EN
    logic             r_prev;
    logic             w_prev_n;
`endif

    assign w_last   = (r_cnt == LAST_CNT);
    assign w_accept = (r_state == IDLE) && run;
    assign w_step   = (r_state == BUSY) && run;
    // The product lives in the working registers; no separate result copy.
    assign z        = {r_acc[OP_W-1:0], r_q};

    mul_iter_step u_step (
        .i_acc      (r_acc),
        .i_q        (r_q),
`ifdef MUL_ITER_RADIX4_EN
        .i_prev     (r_prev),
        .o_prev     (w_prev_n),
`endif
        .i_xe       (r_xe),
        .i_last     (w_last),
        .i_unsigned (r_uns),
        .o_acc      (w_acc_n),
        .o_q        (w_q_n)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and stall decode. Dropping run anywhere returns to IDLE.
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            IDLE: begin
                stall  = run;
                w_next = run ? BUSY : IDLE;
            end
            BUSY: begin
                stall = 1'b1;
                if (!run) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = BUSY;
                end
            end
            DONE: begin
                stall  = 1'b0;
                w_next = run ? DONE : IDLE;
            end
            default: begin
                stall  = run;
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept, one iteration per BUSY cycle, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_xe   <= '0;
            r_uns  <= 1'b0;
`ifdef MUL_ITER_RADIX4_EN
            r_prev <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_q    <= y;
            r_xe   <= ext_operand(x, op_unsigned);
            r_uns  <= op_unsigned;
`ifdef MUL_ITER_RADIX4_EN
            r_prev <= 1'b0;
`endif
        end else if (w_step) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_acc  <= w_acc_n;
            r_q    <= w_q_n;
`ifdef MUL_ITER_RADIX4_EN
            r_prev <= w_prev_n;
`endif
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter -- self-checking bench for mul_iter: reset state, table of
// corner products, DONE hold, operand hold, abort, reset mid-operation and a
// random regression against an arithmetic reference model.
module tb_mul_iter;

`ifdef MUL_ITER_RADIX4_EN
    localparam int EXP_LAT = 17;
`else
    localparam int EXP_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        op_unsigned;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [63:0] z;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        uns;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    mul_iter dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .op_unsigned (op_unsigned),
        .x           (x),
        .y           (y),
        .stall       (stall),
        .z           (z)
    );

    // Reference: extend both operands to 64 bits and multiply modulo 2^64.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic uns);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = uns ? {32'd0, a} : {{32{a[31]}}, a};
        eb = uns ? {32'd0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns in the first cycle with
    // stall low. lat counts stall-high cycles including the accept cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                          input bit scramble, output logic [63:0] res, output int lat);
        lat = 0;
        run = 1'b1;
        x = a;
        y = b;
        op_unsigned = uns;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!stall) break;
            lat++;
            @(negedge clk);
            if (scramble) begin
                x = $urandom;
                y = $urandom;
                op_unsigned = 1'($urandom_range(0, 1));
            end
        end
        res = z;
    endtask

    // One run-low cycle between operations.
    task automatic gap();
        run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] res;
        logic [63:0] exp_z;
        int          lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ru;

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 64'hFFFFFFFFFFFFFFFE};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 64'hFFFFFFFF80000000};
        vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 64'h3FFFFFFF00000001};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h0000000000000001};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vecs[7] = '{32'h00000000, 32'hDEADBEEF, 1'b0, 64'h0000000000000000};
        vecs[8] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'h00000001FFFFFFFE};
        vecs[9] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 64'hC000000080000000};

        // Reset state
        rst = 1'b1;
        run = 1'b0;
        op_unsigned = 1'b0;
        x = 32'd0;
        y = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_z", z, 64'd0);
        check("rst_stall_run0", {63'd0, stall}, 64'd0);
        run = 1'b1;
        #1;
        check("rst_stall_run1", {63'd0, stall}, 64'd1);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Corner table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].uns, 1'b0, res, lat);
            check($sformatf("vec%0d_z", i), res, vecs[i].prod);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(EXP_LAT));
            gap();
        end

        // DONE holds z with run high; no re-accept; z kept in IDLE
        exp_z = ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b1);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, res, lat);
        check("hold_z", res, exp_z);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = $urandom;
            y = $urandom;
            #1;
            check($sformatf("done_stall%0d", i), {63'd0, stall}, 64'd0);
            check($sformatf("done_z%0d", i), z, exp_z);
        end
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle_z%0d", i), z, exp_z);
            check($sformatf("idle_stall%0d", i), {63'd0, stall}, 64'd0);
        end
        @(negedge clk);

        // Operands changing every BUSY cycle do not disturb the result
        run_op(32'd3, 32'd5, 1'b0, 1'b1, res, lat);
        check("opnd_hold_z", res, 64'h000000000000000F);
        check("opnd_hold_lat", 64'(lat), 64'(EXP_LAT));
        gap();

        // Abort in BUSY cycle 10, restart two cycles later
        run = 1'b1;
        x = 32'h00001234;
        y = 32'h00005678;
        op_unsigned = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        run = 1'b0;
        #1;
        check("abort_busy_stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        #1;
        check("abort_idle_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        run_op(32'd7, 32'd6, 1'b1, 1'b0, res, lat);
        check("abort_z", res, 64'h000000000000002A);
        check("abort_lat", 64'(lat), 64'(EXP_LAT));
        gap();

        // Reset pulsed in BUSY cycle 5
        run = 1'b1;
        x = 32'h0000ABCD;
        y = 32'h00001234;
        op_unsigned = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_z", z, 64'd0);
        check("midrst_stall_run1", {63'd0, stall}, 64'd1);
        run = 1'b0;
        #1;
        check("midrst_stall_run0", {63'd0, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(32'd2, 32'd3, 1'b0, 1'b0, res, lat);
        check("midrst_z_after", res, 64'h0000000000000006);
        check("midrst_lat", 64'(lat), 64'(EXP_LAT));
        gap();

        // Random regression
        for (int i = 0; i < 2500; i++) begin
            ra = $urandom;
            rb = $urandom;
            ru = 1'($urandom_range(0, 1));
            run_op(ra, rb, ru, 1'b0, res, lat);
            check($sformatf("rand%0d_z", i), res, ref_mul(ra, rb, ru));
            check($sformatf("rand%0d_lat", i), 64'(lat), 64'(EXP_LAT));
            gap();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
